// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the issue scoreboard: operand-select encodings and
// scoreboard sizing defaults.
package issue_scoreboard_pkg;

  localparam logic RS1_SEL_TMP_RS1_DATA = 1'b0;
  localparam logic RS1_SEL_E_OUT        = 1'b1;
  localparam logic RS2_SEL_TMP_RS2_DATA = 1'b0;
  localparam logic RS2_SEL_E_OUT        = 1'b1;

  localparam int SB_CNT_MAX_DEFAULT = 3;
  localparam int SB_ZERO_REG        = 0;

endpackage

// File: rtl/issue_scoreboard_sb_counter.sv
// Per-register in-flight counter for long-latency writes: counts issues up,
// completions down, and flags a completion that arrives with nothing pending.
module sb_counter #(
  parameter int CW  = 2,
  parameter int MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_wb_hit,
  output logic [CW-1:0] o_cnt,
  output logic          o_busy,
  output logic          o_err
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_dec;

  assign w_dec  = i_wb_hit && (r_cnt != {CW{1'b0}});
  assign o_err  = i_wb_hit && (r_cnt == {CW{1'b0}});
  assign o_busy = (r_cnt != {CW{1'b0}});
  assign o_cnt  = r_cnt;

  // Next count: an issue and a completion in the same cycle cancel out
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && !w_dec) begin
      if (r_cnt != CW'(MAX)) begin
        w_cnt_nxt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else if (w_dec && !i_inc) begin
      w_cnt_nxt = r_cnt - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode/execute hazard unit: per-register long-write tracking, a one-entry
// execute shadow for forwarding, issue permission and operand selects.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter  int NREGS        = 32,
  parameter  int MAX_INFLIGHT = SB_CNT_MAX_DEFAULT,
  localparam int RW           = $clog2(NREGS),
  localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic          id_reg_we,
  input  logic          id_long,
  input  logic          id_serialize,
  input  logic          ex_ready,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_rd,
  input  logic          flush,
  output logic          issue_ok,
  output logic          rs1_sel,
  output logic          rs2_sel,
  output logic          idle,
  output logic          sb_err
);

  localparam logic [RW-1:0] ZERO_REG = RW'(SB_ZERO_REG);

  logic [CW-1:0]    w_cnt [NREGS];
  logic [NREGS-1:0] w_busy;
  logic [NREGS-1:0] w_err;
  logic             w_fire;
  logic             w_inc;
  logic             w_haz_rs1;
  logic             w_haz_rs2;
  logic             w_haz_waw;
  logic             w_haz_ser;

  logic             r_e_valid;
  logic [RW-1:0]    r_e_rd;
  logic             r_e_we;
  logic             r_sb_err;

  assign w_cnt[0]  = {CW{1'b0}};
  assign w_busy[0] = 1'b0;
  assign w_err[0]  = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_cnt
    sb_counter #(
      .CW  (CW),
      .MAX (MAX_INFLIGHT)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_inc    (w_inc && (id_rd == RW'(g))),
      .i_wb_hit (wb_valid && (wb_rd == RW'(g))),
      .o_cnt    (w_cnt[g]),
      .o_busy   (w_busy[g]),
      .o_err    (w_err[g])
    );
  end

  // Hazards depend only on registered state and decode inputs, never on wb_* or ex_ready
  always_comb begin
    w_haz_rs1 = id_use_rs1 && (id_rs1 != ZERO_REG) && (w_cnt[id_rs1] != {CW{1'b0}});
    w_haz_rs2 = id_use_rs2 && (id_rs2 != ZERO_REG) && (w_cnt[id_rs2] != {CW{1'b0}});
    w_haz_waw = id_reg_we && id_long && (id_rd != ZERO_REG) &&
                (w_cnt[id_rd] == CW'(MAX_INFLIGHT));
    w_haz_ser = id_serialize && !idle;
    if (id_valid) begin
      issue_ok = !(w_haz_rs1 || w_haz_rs2 || w_haz_waw || w_haz_ser);
    end else begin
      issue_ok = 1'b1;
    end
  end

  assign idle   = ~|w_busy;
  assign w_fire = id_valid && issue_ok && ex_ready;
  assign w_inc  = w_fire && id_reg_we && id_long && (id_rd != ZERO_REG);
  assign sb_err = r_sb_err;

  // Forwarding selects from the execute shadow
  always_comb begin
    rs1_sel = RS1_SEL_TMP_RS1_DATA;
    rs2_sel = RS2_SEL_TMP_RS2_DATA;
    if (id_use_rs1 && r_e_valid && r_e_we && (r_e_rd != ZERO_REG) && (r_e_rd == id_rs1)) begin
      rs1_sel = RS1_SEL_E_OUT;
    end else begin
      rs1_sel = RS1_SEL_TMP_RS1_DATA;
    end
    if (id_use_rs2 && r_e_valid && r_e_we && (r_e_rd != ZERO_REG) && (r_e_rd == id_rs2)) begin
      rs2_sel = RS2_SEL_E_OUT;
    end else begin
      rs2_sel = RS2_SEL_TMP_RS2_DATA;
    end
  end

  // Execute shadow: only short writers are captured; long ops wait for writeback instead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_valid <= 1'b0;
      r_e_rd    <= {RW{1'b0}};
      r_e_we    <= 1'b0;
    end else if (ex_ready) begin
      if (!flush && w_fire && id_reg_we && !id_long) begin
        r_e_valid <= 1'b1;
        r_e_rd    <= id_rd;
        r_e_we    <= 1'b1;
      end else begin
        r_e_valid <= 1'b0;
        r_e_rd    <= {RW{1'b0}};
        r_e_we    <= 1'b0;
      end
    end else begin
      r_e_valid <= r_e_valid;
      r_e_rd    <= r_e_rd;
      r_e_we    <= r_e_we;
    end
  end

  // Sticky error for a completion with nothing outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else begin
      r_sb_err <= r_sb_err | (|w_err);
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: hand-computed expectations for
// forwarding, load-use, saturation, serialize, flush, error and reset.
module tb_issue_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_reg_we;
  logic       id_long;
  logic       id_serialize;
  logic       ex_ready;
  logic       wb_valid;
  logic [4:0] wb_rd;
  logic       flush;
  logic       issue_ok;
  logic       rs1_sel;
  logic       rs2_sel;
  logic       idle;
  logic       sb_err;

  int n_cmp;
  int n_mis;

  issue_scoreboard #(.NREGS(32), .MAX_INFLIGHT(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_reg_we    (id_reg_we),
    .id_long      (id_long),
    .id_serialize (id_serialize),
    .ex_ready     (ex_ready),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .flush        (flush),
    .issue_ok     (issue_ok),
    .rs1_sel      (rs1_sel),
    .rs2_sel      (rs2_sel),
    .idle         (idle),
    .sb_err       (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    wb_rd    = 5'd0;
    flush    = 1'b0;
  endtask

  task automatic id_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic we,
                        input logic lng, input logic ser);
    id_valid     = 1'b1;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    id_reg_we    = we;
    id_long      = lng;
    id_serialize = ser;
  endtask

  task automatic id_none();
    id_req(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd);
    wb_valid = 1'b1;
    wb_rd    = rd;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst_n = 1'b0;
    ex_ready = 1'b1;
    wb_valid = 1'b0;
    wb_rd = 5'd0;
    flush = 1'b0;
    id_none();
    #3;
    chk_eq("rst_issue_ok", issue_ok, 1);
    chk_eq("rst_idle", idle, 1);
    chk_eq("rst_rs1_sel", rs1_sel, 0);
    chk_eq("rst_rs2_sel", rs2_sel, 0);
    chk_eq("rst_sb_err", sb_err, 0);
    #5 rst_n = 1'b1;
    tick();

    // short producer then dependent: forward from E
    id_req(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk_eq("fwd_prod_ok", issue_ok, 1);
    tick();
    id_req(5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk_eq("fwd_ok", issue_ok, 1);
    chk_eq("fwd_rs1_sel", rs1_sel, 1);
    chk_eq("fwd_rs2_sel", rs2_sel, 1);
    tick();
    id_none();
    tick();

    // load-use
    id_req(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1 chk_eq("lu_load_ok", issue_ok, 1);
    tick();
    id_req(5'd7, 5'd0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk_eq("lu_stall", issue_ok, 0);
    chk_eq("lu_busy", idle, 0);
    tick();
    wb(5'd7);
    #1 chk_eq("lu_no_wb_bypass", issue_ok, 0);
    tick();
    #1 chk_eq("lu_release", issue_ok, 1);
    chk_eq("lu_sel_tmp", rs1_sel, 0);
    chk_eq("lu_idle", idle, 1);
    tick();
    id_none();
    tick();

    // saturation on x3
    for (int i = 0; i < 3; i++) begin
      id_req(5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1 chk_eq("sat_issue", issue_ok, 1);
      tick();
    end
    #1 chk_eq("sat_full", issue_ok, 0);
    wb(5'd3);
    #1 chk_eq("sat_full_wb", issue_ok, 0);
    tick();
    #1 chk_eq("sat_release", issue_ok, 1);
    tick();
    id_req(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1 chk_eq("sat_x9_ok", issue_ok, 1);
    tick();
    id_none();
    wb(5'd9);
    tick();
    #1 chk_eq("ooo_busy_a", idle, 0);
    wb(5'd3);
    tick();
    wb(5'd3);
    tick();
    #1 chk_eq("ooo_busy_b", idle, 0);
    wb(5'd3);
    tick();
    #1 chk_eq("ooo_idle", idle, 1);
    chk_eq("ooo_no_err", sb_err, 0);

    // same-cycle inc and dec on x4
    id_req(5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    wb(5'd4);
    #1 chk_eq("simul_ok", issue_ok, 1);
    tick();
    id_req(5'd4, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk_eq("simul_stall", issue_ok, 0);
    wb(5'd4);
    tick();
    id_none();
    #1 chk_eq("simul_idle", idle, 1);

    // x0 is never tracked nor forwarded
    id_req(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    id_req(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    #1 chk_eq("x0_ok", issue_ok, 1);
    chk_eq("x0_idle", idle, 1);
    tick();
    id_req(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_req(5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 chk_eq("x0_sel_tmp", rs1_sel, 0);
    tick();

    // serialize
    id_req(5'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    id_req(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 chk_eq("ser_stall", issue_ok, 0);
    wb(5'd12);
    tick();
    #1 chk_eq("ser_ok", issue_ok, 1);
    tick();

    // flush kills forwarding but not counters
    id_req(5'd0, 5'd0, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    id_req(5'd13, 5'd13, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk_eq("fl_rs1_tmp", rs1_sel, 0);
    chk_eq("fl_rs2_tmp", rs2_sel, 0);
    chk_eq("fl_ok", issue_ok, 1);
    tick();
    id_req(5'd0, 5'd0, 5'd14, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    id_req(5'd14, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk_eq("fl_cnt_kept", issue_ok, 0);
    wb(5'd14);
    tick();
    #1 chk_eq("fl_cnt_release", issue_ok, 1);
    chk_eq("fl_idle", idle, 1);
    id_none();
    tick();

    // ex_ready low holds the shadow and blocks issue
    id_req(5'd0, 5'd0, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    id_req(5'd0, 5'd0, 5'd16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    ex_ready = 1'b0;
    tick();
    #1 chk_eq("nordy_no_inc", idle, 1);
    ex_ready = 1'b1;
    id_req(5'd15, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk_eq("hold_sel_eout", rs1_sel, 1);
    tick();
    id_none();
    tick();

    // completion with nothing pending
    #1 chk_eq("err_pre", sb_err, 0);
    wb(5'd8);
    tick();
    #1 chk_eq("err_set", sb_err, 1);
    tick();
    tick();
    #1 chk_eq("err_sticky", sb_err, 1);

    // async reset mid-stream
    id_req(5'd0, 5'd0, 5'd20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    id_none();
    #1 chk_eq("mid_busy", idle, 0);
    rst_n = 1'b0;
    #1 chk_eq("arst_idle", idle, 1);
    chk_eq("arst_err", sb_err, 0);
    chk_eq("arst_ok", issue_ok, 1);
    #2 rst_n = 1'b1;
    tick();
    wb(5'd20);
    tick();
    #1 chk_eq("post_rst_wb_err", sb_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
